// File: rtl/axi_rd_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_slave_mem
// Description : AXI4 read slave with AR queue, FIXED/INCR/WRAP beat engine
//               and a backdoor-loadable word memory.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_slave_mem #(
    parameter int AWID_WIDTH    = 4,
    parameter int AWADDR_WIDTH  = 32,
    parameter int WDATA_WIDTH   = 64,
    parameter int MEM_DEPTH     = 256,
    parameter int AR_FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AWID_WIDTH-1:0]        ARID,
    input  logic [AWADDR_WIDTH-1:0]      ARADDR,
    input  logic [7:0]                   ARLEN,
    input  logic [2:0]                   ARSIZE,
    input  logic [1:0]                   ARBURST,
    input  logic [3:0]                   ARREGION,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [AWID_WIDTH-1:0]        RID,
    output logic [WDATA_WIDTH-1:0]       RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RLAST,
    output logic                         RVALID,
    input  logic                         RREADY,
    input  logic                         bd_wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] bd_wr_addr,
    input  logic [WDATA_WIDTH-1:0]       bd_wr_data
);

    localparam int c_BSHIFT = $clog2(WDATA_WIDTH / 8);
    localparam int c_IW     = $clog2(MEM_DEPTH);
    localparam int c_FW     = $clog2(AR_FIFO_DEPTH);
    localparam logic [c_FW:0]         c_FULL = (c_FW+1)'(AR_FIFO_DEPTH);
    localparam logic [AWADDR_WIDTH-1:0] c_ONE = AWADDR_WIDTH'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_BURST = 2'd2;

    // Error conditions that apply to every beat of a burst
    function automatic logic f_burst_err(
        input logic [AWADDR_WIDTH-1:0] a,
        input logic [7:0]              len,
        input logic [2:0]              size,
        input logic [1:0]              burst
    );
        logic [AWADDR_WIDTH-1:0] s_mask;
        logic                    err;
        s_mask = (c_ONE << size) - c_ONE;
        err    = (int'(size) > c_BSHIFT) || (burst == 2'd3);
        if (burst == 2'd2) begin
            if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
                err = 1'b1;
            if ((a & s_mask) != '0)
                err = 1'b1;
        end
        return err;
    endfunction

    // Address of the beat following the one at a
    function automatic logic [AWADDR_WIDTH-1:0] f_next_addr(
        input logic [AWADDR_WIDTH-1:0] a,
        input logic [7:0]              len,
        input logic [2:0]              size,
        input logic [1:0]              burst
    );
        logic [AWADDR_WIDTH-1:0] s;
        logic [AWADDR_WIDTH-1:0] t;
        logic [AWADDR_WIDTH-1:0] nxt;
        s = c_ONE << size;
        t = (AWADDR_WIDTH'(len) + c_ONE) << size;
        case (burst)
            2'd0:    nxt = a;
            2'd2:    nxt = (a & ~(t - c_ONE)) | ((a + s) & (t - c_ONE));
            default: nxt = (a & ~(s - c_ONE)) + s;
        endcase
        return nxt;
    endfunction

    // ---------------- AR request queue ----------------
    logic [AWID_WIDTH-1:0]   r_q_id    [AR_FIFO_DEPTH];
    logic [AWADDR_WIDTH-1:0] r_q_addr  [AR_FIFO_DEPTH];
    logic [7:0]              r_q_len   [AR_FIFO_DEPTH];
    logic [2:0]              r_q_size  [AR_FIFO_DEPTH];
    logic [1:0]              r_q_burst [AR_FIFO_DEPTH];
    logic [c_FW-1:0]         r_wr_ptr;
    logic [c_FW-1:0]         r_rd_ptr;
    logic [c_FW:0]           r_count;
    logic [c_FW:0]           w_count_nxt;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_unused_region;

    assign w_unused_region = ^ARREGION;
    assign w_push      = ARVALID & ARREADY;
    assign w_count_nxt = r_count + (c_FW+1)'(w_push) - (c_FW+1)'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_id[r_wr_ptr]    <= ARID;
            r_q_addr[r_wr_ptr]  <= ARADDR;
            r_q_len[r_wr_ptr]   <= ARLEN;
            r_q_size[r_wr_ptr]  <= ARSIZE;
            r_q_burst[r_wr_ptr] <= ARBURST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            ARREADY  <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_FW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_FW'(1);
            r_count <= w_count_nxt;
            ARREADY <= (w_count_nxt != c_FULL);
        end
    end

    logic [AWID_WIDTH-1:0]   w_h_id;
    logic [AWADDR_WIDTH-1:0] w_h_addr;
    logic [7:0]              w_h_len;
    logic [2:0]              w_h_size;
    logic [1:0]              w_h_burst;
    logic                    w_h_err;

    assign w_h_id    = r_q_id[r_rd_ptr];
    assign w_h_addr  = r_q_addr[r_rd_ptr];
    assign w_h_len   = r_q_len[r_rd_ptr];
    assign w_h_size  = r_q_size[r_rd_ptr];
    assign w_h_burst = r_q_burst[r_rd_ptr];
    assign w_h_err   = f_burst_err(w_h_addr, w_h_len, w_h_size, w_h_burst);

    // ---------------- burst context ----------------
    logic [AWID_WIDTH-1:0]   r_id;
    logic [AWADDR_WIDTH-1:0] r_addr;   // address of the next beat to load
    logic [7:0]              r_nbeat;  // index of the next beat to load
    logic [7:0]              r_len;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic                    r_err;

    // ---------------- control FSM ----------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_ld_ctx;
    logic       w_ld_beat;
    logic       w_src_head;
    logic       w_rv_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= c_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_ld_ctx    = 1'b0;
        w_ld_beat   = 1'b0;
        w_src_head  = 1'b0;
        w_rv_clr    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_ld_ctx    = 1'b1;
                    w_state_nxt = c_START;
                end
            end
            c_START: begin
                w_ld_beat   = 1'b1;
                w_state_nxt = c_BURST;
            end
            c_BURST: begin
                if (RVALID && RREADY) begin
                    if (!RLAST) begin
                        w_ld_beat = 1'b1;
                    end else if (r_count != '0) begin
                        // chain straight into the next burst from the queue head
                        w_pop      = 1'b1;
                        w_ld_ctx   = 1'b1;
                        w_ld_beat  = 1'b1;
                        w_src_head = 1'b1;
                    end else begin
                        w_rv_clr    = 1'b1;
                        w_state_nxt = c_IDLE;
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ---------------- beat source and memory access ----------------
    logic [AWID_WIDTH-1:0]   w_s_id;
    logic [AWADDR_WIDTH-1:0] w_s_addr;
    logic [7:0]              w_s_idx;
    logic [7:0]              w_s_len;
    logic [2:0]              w_s_size;
    logic [1:0]              w_s_burst;
    logic                    w_s_err;
    logic [AWADDR_WIDTH-1:0] w_word;
    logic                    w_beat_err;
    logic [c_IW-1:0]         w_mem_idx;
    logic [WDATA_WIDTH-1:0]  r_mem [MEM_DEPTH];

    assign w_s_id     = w_src_head ? w_h_id    : r_id;
    assign w_s_addr   = w_src_head ? w_h_addr  : r_addr;
    assign w_s_idx    = w_src_head ? 8'd0      : r_nbeat;
    assign w_s_len    = w_src_head ? w_h_len   : r_len;
    assign w_s_size   = w_src_head ? w_h_size  : r_size;
    assign w_s_burst  = w_src_head ? w_h_burst : r_burst;
    assign w_s_err    = w_src_head ? w_h_err   : r_err;
    assign w_word     = w_s_addr >> c_BSHIFT;
    assign w_beat_err = w_s_err || (w_word >= AWADDR_WIDTH'(MEM_DEPTH));
    assign w_mem_idx  = w_word[c_IW-1:0];

    // Backdoor and beat load share an edge; the beat sees the old word
    always_ff @(posedge clk) begin
        if (bd_wr_en)
            r_mem[bd_wr_addr] <= bd_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_nbeat <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
            RID     <= '0;
            RDATA   <= '0;
            RRESP   <= '0;
            RLAST   <= 1'b0;
            RVALID  <= 1'b0;
        end else begin
            if (w_ld_ctx) begin
                r_id    <= w_h_id;
                r_addr  <= w_h_addr;
                r_nbeat <= 8'd0;
                r_len   <= w_h_len;
                r_size  <= w_h_size;
                r_burst <= w_h_burst;
                r_err   <= w_h_err;
            end
            if (w_ld_beat) begin
                RID     <= w_s_id;
                RDATA   <= w_beat_err ? '0 : r_mem[w_mem_idx];
                RRESP   <= w_beat_err ? 2'b10 : 2'b00;
                RLAST   <= (w_s_idx == w_s_len);
                RVALID  <= 1'b1;
                r_addr  <= f_next_addr(w_s_addr, w_s_len, w_s_size, w_s_burst);
                r_nbeat <= w_s_idx + 8'd1;
            end else if (w_rv_clr) begin
                RVALID <= 1'b0;
                RLAST  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_slave_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_slave_mem
// Description : Self-checking bench for axi_rd_slave_mem against a
//               burst-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_slave_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic [3:0]  ARREGION = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        bd_wr_en = 1'b0;
    logic [7:0]  bd_wr_addr = '0;
    logic [63:0] bd_wr_data = '0;

    always #5 clk = ~clk;

    axi_rd_slave_mem #(
        .AWID_WIDTH(4), .AWADDR_WIDTH(32), .WDATA_WIDTH(64),
        .MEM_DEPTH(256), .AR_FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .bd_wr_en(bd_wr_en), .bd_wr_addr(bd_wr_addr), .bd_wr_data(bd_wr_data)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] mem_m [256];
    logic [3:0]  exp_id[$];
    logic [63:0] exp_data[$];
    logic [1:0]  exp_resp[$];
    logic        exp_last[$];
    logic [3:0]  got_id[$];
    logic [63:0] got_data[$];
    logic [1:0]  got_resp[$];
    logic        got_last[$];
    int          got_cyc[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input int idx, input logic [63:0] d);
        bd_wr_en   = 1'b1;
        bd_wr_addr = idx[7:0];
        bd_wr_data = d;
        tick();
        bd_wr_en   = 1'b0;
        mem_m[idx] = d;
    endtask

    task automatic clear_exp();
        exp_id.delete(); exp_data.delete(); exp_resp.delete(); exp_last.delete();
    endtask

    // Reference: expected beats of one burst, from the address rules directly
    task automatic model_burst(input logic [3:0] id, input logic [31:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst);
        longint s, t, lo, a, word;
        bit berr, err;
        s  = longint'(1) << size;
        t  = (longint'(len) + 1) * s;
        lo = longint'(addr) & ~(t - 1);
        berr = (s > 8) || (burst == 2'd3) ||
               (burst == 2'd2 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ||
               (burst == 2'd2 && (longint'(addr) % s) != 0);
        a = longint'(addr);
        for (int n = 0; n <= int'(len); n++) begin
            if (n > 0) begin
                case (burst)
                    2'd0:    a = longint'(addr);
                    2'd1:    a = ((longint'(addr) & ~(s - 1)) + longint'(n) * s) & 64'hFFFF_FFFF;
                    default: begin
                        a = a + s;
                        if (a == lo + t) a = lo;
                    end
                endcase
            end
            word = a / 8;
            err  = berr || (word >= 256);
            exp_id.push_back(id);
            exp_data.push_back(err ? 64'd0 : mem_m[word[7:0]]);
            exp_resp.push_back(err ? 2'd2 : 2'd0);
            exp_last.push_back(n == int'(len));
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, output bit ok);
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        ARREGION = 4'($urandom_range(15));
        ARVALID = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            if (ARREADY) ok = 1'b1;
            tick();
        end
        ARVALID = 1'b0;
    endtask

    // Collects n R beats (no judging); rnd selects random RREADY
    task automatic recv_beats(input int n, input bit rnd, output bit ok);
        int cnt;
        got_id.delete(); got_data.delete(); got_resp.delete();
        got_last.delete(); got_cyc.delete();
        cnt = 0;
        for (int c = 0; c < 5000 && cnt < n; c++) begin
            RREADY = rnd ? ($urandom_range(3) != 0) : 1'b1;
            if (RVALID && RREADY) begin
                got_id.push_back(RID);
                got_data.push_back(RDATA);
                got_resp.push_back(RRESP);
                got_last.push_back(RLAST);
                got_cyc.push_back(c);
                cnt++;
            end
            tick();
        end
        RREADY = 1'b0;
        ok = (cnt == n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) bd_write(i, {$urandom, $urandom});
        checks++;
        if ({ARREADY, RVALID, RLAST, RID, RDATA, RRESP} !== '0) begin
            errors++;
            $display("FAIL reset_values: got ARREADY=%b RVALID=%b RLAST=%b RID=%h RDATA=%h RRESP=%h required all 0",
                     ARREADY, RVALID, RLAST, RID, RDATA, RRESP);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (ARREADY !== 1'b1) begin
            errors++; $display("FAIL reset_arready: got %b required 1", ARREADY);
        end
        checks++;
        if (RVALID !== 1'b0) begin
            errors++; $display("FAIL reset_rvalid: got %b required 0", RVALID);
        end
    endtask

    task automatic test_single();
        bit ok;
        bd_write(4, 64'hA5A5_0000_0000_0004);
        send_ar(4'd3, 32'h20, 8'd0, 3'd3, 2'd1, ok);
        checks++;
        if (!ok || RVALID !== 1'b0) begin
            errors++; $display("FAIL single_lat0: ok=%0d RVALID=%b required handshake and 0", ok, RVALID);
        end
        tick();
        checks++;
        if (RVALID !== 1'b0) begin
            errors++; $display("FAIL single_lat1: got RVALID=%b required 0", RVALID);
        end
        tick();
        checks++;
        if ({RVALID, RID, RDATA, RRESP, RLAST} !== {1'b1, 4'd3, 64'hA5A5_0000_0000_0004, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_beat: got V=%b ID=%h D=%h RESP=%h LAST=%b required V=1 ID=3 D=a5a5000000000004 RESP=0 LAST=1",
                     RVALID, RID, RDATA, RRESP, RLAST);
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        checks++;
        if (RVALID !== 1'b0) begin
            errors++; $display("FAIL single_idle: got RVALID=%b required 0", RVALID);
        end
    endtask

    task automatic test_backpressure();
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int k, c;
        bit ok;
        for (int i = 0; i < 4; i++) bd_write(i, 64'(i));
        clear_exp();
        model_burst(4'd6, 32'h0, 8'd3, 3'd3, 2'd1);
        send_ar(4'd6, 32'h0, 8'd3, 3'd3, 2'd1, ok);
        for (int w = 0; w < 10 && !RVALID; w++) tick();
        k = 0;
        c = 0;
        while (k < 4 && c < 40) begin
            RREADY = (c < 7) ? pat[c][0] : 1'b1;
            if (RVALID) begin
                checks++;
                if ({RID, RDATA, RRESP, RLAST} !== {exp_id[k], exp_data[k], exp_resp[k], exp_last[k]}) begin
                    errors++;
                    $display("FAIL bp_beat%0d: got ID=%h D=%h RESP=%h LAST=%b required ID=%h D=%h RESP=%h LAST=%b",
                             k, RID, RDATA, RRESP, RLAST, exp_id[k], exp_data[k], exp_resp[k], exp_last[k]);
                end
                if (RREADY) k++;
            end
            tick();
            c++;
        end
        RREADY = 1'b0;
        checks++;
        if (k != 4 || !ok) begin
            errors++; $display("FAIL bp_count: got %0d beats required 4", k);
        end
    endtask

    task automatic test_wrap();
        bit ok, rok;
        logic [63:0] want[4] = '{64'd10, 64'd11, 64'd8, 64'd9};
        for (int i = 8; i < 12; i++) bd_write(i, 64'(i));
        send_ar(4'd9, 32'h50, 8'd3, 3'd3, 2'd2, ok);
        recv_beats(4, 1'b0, rok);
        checks++;
        if (!ok || !rok) begin
            errors++; $display("FAIL wrap_timeout: got %0d beats required 4", got_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({got_data[i], got_resp[i], got_last[i]} !== {want[i], 2'd0, (i == 3)}) begin
                    errors++;
                    $display("FAIL wrap_beat%0d: got D=%h RESP=%h LAST=%b required D=%h RESP=0 LAST=%0d",
                             i, got_data[i], got_resp[i], got_last[i], want[i], (i == 3));
                end
            end
        end
    endtask

    task automatic test_queue();
        bit sok, rok;
        clear_exp();
        RREADY = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            ARID = k[3:0]; ARADDR = 32'(k * 8); ARLEN = 8'd0; ARSIZE = 3'd3; ARBURST = 2'd1;
            ARVALID = 1'b1;
            model_burst(k[3:0], 32'(k * 8), 8'd0, 3'd3, 2'd1);
            checks++;
            if (ARREADY !== 1'b1) begin
                errors++; $display("FAIL queue_accept%0d: got ARREADY=%b required 1", k, ARREADY);
            end
            tick();
        end
        ARID = 4'd6; ARADDR = 32'h30;
        model_burst(4'd6, 32'h30, 8'd0, 3'd3, 2'd1);
        checks++;
        if ({ARREADY, RVALID, RID} !== {1'b0, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL queue_full: got ARREADY=%b RVALID=%b RID=%h required 0 1 1", ARREADY, RVALID, RID);
        end
        tick(); tick();
        checks++;
        if (ARREADY !== 1'b0) begin
            errors++; $display("FAIL queue_hold: got ARREADY=%b required 0", ARREADY);
        end
        fork
            send_ar(4'd6, 32'h30, 8'd0, 3'd3, 2'd1, sok);
            recv_beats(6, 1'b0, rok);
        join
        checks++;
        if (!sok || !rok) begin
            errors++; $display("FAIL queue_timeout: got %0d beats required 6", got_id.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if ({got_id[i], got_data[i], got_last[i]} !== {exp_id[i], exp_data[i], exp_last[i]}) begin
                    errors++;
                    $display("FAIL queue_order%0d: got ID=%h D=%h required ID=%h D=%h",
                             i, got_id[i], got_data[i], exp_id[i], exp_data[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (got_cyc[i] - got_cyc[i-1] != 1) begin
                        errors++;
                        $display("FAIL queue_gap%0d: got %0d cycles required 1", i, got_cyc[i] - got_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_errors();
        bit ok, rok;
        bd_write(255, 64'hDEAD_BEEF_0000_00FF);
        clear_exp();
        model_burst(4'd2, 32'h0,   8'd1, 3'd4, 2'd1);
        model_burst(4'd3, 32'h7F8, 8'd1, 3'd3, 2'd1);
        model_burst(4'd4, 32'h40,  8'd2, 3'd3, 2'd2);
        model_burst(4'd5, 32'h10,  8'd0, 3'd3, 2'd3);
        send_ar(4'd2, 32'h0,   8'd1, 3'd4, 2'd1, ok);
        send_ar(4'd3, 32'h7F8, 8'd1, 3'd3, 2'd1, ok);
        send_ar(4'd4, 32'h40,  8'd2, 3'd3, 2'd2, ok);
        send_ar(4'd5, 32'h10,  8'd0, 3'd3, 2'd3, ok);
        recv_beats(8, 1'b1, rok);
        checks++;
        if (!rok) begin
            errors++; $display("FAIL err_timeout: got %0d beats required 8", got_data.size());
        end else begin
            checks++;
            if ({got_resp[0], got_data[0], got_last[0], got_resp[1], got_data[1], got_last[1]} !==
                {2'd2, 64'd0, 1'b0, 2'd2, 64'd0, 1'b1}) begin
                errors++;
                $display("FAIL err_size: got RESP=%h,%h D=%h,%h LAST=%b,%b required 2,2 0,0 0,1",
                         got_resp[0], got_resp[1], got_data[0], got_data[1], got_last[0], got_last[1]);
            end
            checks++;
            if ({got_resp[2], got_data[2], got_resp[3], got_data[3]} !==
                {2'd0, 64'hDEAD_BEEF_0000_00FF, 2'd2, 64'd0}) begin
                errors++;
                $display("FAIL err_range: got RESP=%h D=%h / RESP=%h D=%h required 0 deadbeef000000ff / 2 0",
                         got_resp[2], got_data[2], got_resp[3], got_data[3]);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if ({got_id[i], got_data[i], got_resp[i], got_last[i]} !==
                    {exp_id[i], exp_data[i], exp_resp[i], exp_last[i]}) begin
                    errors++;
                    $display("FAIL err_beat%0d: got ID=%h D=%h RESP=%h LAST=%b required ID=%h D=%h RESP=%h LAST=%b",
                             i, got_id[i], got_data[i], got_resp[i], got_last[i],
                             exp_id[i], exp_data[i], exp_resp[i], exp_last[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, rok;
        int k, seen;
        clear_exp();
        model_burst(4'd7, 32'h80, 8'd7, 3'd3, 2'd1);
        send_ar(4'd7, 32'h80, 8'd7, 3'd3, 2'd1, ok);
        send_ar(4'd8, 32'h0,  8'd0, 3'd3, 2'd1, ok);
        send_ar(4'd9, 32'h8,  8'd0, 3'd3, 2'd1, ok);
        k = 0;
        RREADY = 1'b1;
        for (int c = 0; c < 50 && k < 2; c++) begin
            if (RVALID) k++;
            tick();
        end
        checks++;
        if ({RVALID, RDATA} !== {1'b1, exp_data[2]}) begin
            errors++; $display("FAIL rstmid_beat2: got V=%b D=%h required V=1 D=%h", RVALID, RDATA, exp_data[2]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({RVALID, RLAST, ARREADY} !== 3'b000) begin
            errors++; $display("FAIL rstmid_async: got V=%b L=%b ARREADY=%b required 000", RVALID, RLAST, ARREADY);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (ARREADY !== 1'b1) begin
            errors++; $display("FAIL rstmid_arready: got %b required 1", ARREADY);
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (RVALID) seen++;
            tick();
        end
        RREADY = 1'b0;
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL rstmid_quiet: got %0d beats required 0", seen);
        end
        clear_exp();
        model_burst(4'd5, 32'h80, 8'd7, 3'd3, 2'd1);
        send_ar(4'd5, 32'h80, 8'd7, 3'd3, 2'd1, ok);
        recv_beats(8, 1'b0, rok);
        checks++;
        if (!rok) begin
            errors++; $display("FAIL rstmid_timeout: got %0d beats required 8", got_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if ({got_data[i], got_last[i]} !== {exp_data[i], exp_last[i]}) begin
                    errors++;
                    $display("FAIL rstmid_mem%0d: got D=%h L=%b required D=%h L=%b",
                             i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        localparam int c_N = 24;
        logic [3:0]  q_id[c_N];
        logic [31:0] q_addr[c_N];
        logic [7:0]  q_len[c_N];
        logic [2:0]  q_size[c_N];
        logic [1:0]  q_burst[c_N];
        bit sfail, rok;
        clear_exp();
        for (int i = 0; i < c_N; i++) begin
            q_id[i]    = 4'($urandom_range(15));
            q_burst[i] = 2'($urandom_range(2));
            if ($urandom_range(15) == 0) q_burst[i] = 2'd3;
            q_size[i]  = 3'($urandom_range(3));
            if ($urandom_range(9) == 0) q_size[i] = 3'd4;
            if (q_burst[i] == 2'd2) begin
                case ($urandom_range(4))
                    0: q_len[i] = 8'd1;
                    1: q_len[i] = 8'd3;
                    2: q_len[i] = 8'd7;
                    3: q_len[i] = 8'd15;
                    default: q_len[i] = 8'd2;
                endcase
            end else begin
                q_len[i] = 8'($urandom_range(7));
            end
            q_addr[i] = 32'($urandom_range(32'h900));
            if (q_burst[i] == 2'd2 && $urandom_range(4) != 0)
                q_addr[i] = q_addr[i] & ~((32'd1 << q_size[i]) - 32'd1);
            model_burst(q_id[i], q_addr[i], q_len[i], q_size[i], q_burst[i]);
        end
        sfail = 1'b0;
        fork
            begin
                for (int i = 0; i < c_N; i++) begin
                    bit ok;
                    repeat ($urandom_range(3)) tick();
                    send_ar(q_id[i], q_addr[i], q_len[i], q_size[i], q_burst[i], ok);
                    if (!ok) sfail = 1'b1;
                end
            end
            recv_beats(exp_data.size(), 1'b1, rok);
        join
        checks++;
        if (sfail || !rok) begin
            errors++; $display("FAIL rand_timeout: got %0d beats required %0d", got_data.size(), exp_data.size());
        end else begin
            for (int i = 0; i < exp_data.size(); i++) begin
                checks++;
                if ({got_id[i], got_data[i], got_resp[i], got_last[i]} !==
                    {exp_id[i], exp_data[i], exp_resp[i], exp_last[i]}) begin
                    errors++;
                    $display("FAIL rand_beat%0d: got ID=%h D=%h RESP=%h LAST=%b required ID=%h D=%h RESP=%h LAST=%b",
                             i, got_id[i], got_data[i], got_resp[i], got_last[i],
                             exp_id[i], exp_data[i], exp_resp[i], exp_last[i]);
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_wrap();
        test_queue();
        test_errors();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
